// File: rtl/tm_frame_scheduler.sv
// Telemetry downlink frame scheduler: arbitrates real-time vs playback frame buffers and streams bytes to the serializer.
// Optional idle fill frames are enabled by defining TM_FILL_FRAME_EN.
module tm_frame_scheduler #(
   parameter int         FRAME_BYTES   = 253,
   parameter int         ADDR_W        = 8,
   parameter int         GAP_BITS      = 16,
   parameter int         MAX_RT_STREAK = 4,
   parameter logic [7:0] FILL_BYTE     = 8'h55
) (
   input  logic              ClkI,
   input  logic              Rst,
   input  logic              ReqRt,
   input  logic              ReqPb,
   input  logic [7:0]        DataRt,
   input  logic [7:0]        DataPb,
   output logic [ADDR_W-1:0] RdAddr,
   output logic              RdSel,
   output logic [7:0]        ByteO,
   output logic              SerEn,
   output logic              DoneRt,
   output logic              DonePb,
   output logic              Busy
);

   localparam int GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam int STREAK_W = $clog2(MAX_RT_STREAK + 1);

   localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(FRAME_BYTES - 1);
   localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RT_STREAK);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREFETCH = 2'd1,
      SEND     = 2'd2,
      GAP      = 2'd3
   } state_t;

   state_t              state_r,   nextState_s;
   logic [ADDR_W-1:0]   rdAddr_r,  rdAddr_s;
   logic                rdSel_r,   rdSel_s;
   logic [7:0]          byteO_r,   byteO_s;
   logic                serEn_r,   serEn_s;
   logic                doneRt_r,  doneRt_s;
   logic                donePb_r,  donePb_s;
   logic                busy_r,    busy_s;
   logic [2:0]          bitCnt_r,  bitCnt_s;
   logic [ADDR_W-1:0]   byteCnt_r, byteCnt_s;
   logic [GAP_W-1:0]    gapCnt_r,  gapCnt_s;
   logic [STREAK_W-1:0] streak_r,  streak_s;
   logic                fill_r,    fill_s;
   logic [7:0]          srcByte_s;
   logic [ADDR_W-1:0]   addrInc_s;

   // Next-state and next-output logic for the scheduler FSM.
   always_comb begin
      nextState_s = state_r;
      rdAddr_s    = rdAddr_r;
      rdSel_s     = rdSel_r;
      byteO_s     = byteO_r;
      serEn_s     = serEn_r;
      doneRt_s    = 1'b0;
      donePb_s    = 1'b0;
      busy_s      = busy_r;
      bitCnt_s    = bitCnt_r;
      byteCnt_s   = byteCnt_r;
      gapCnt_s    = gapCnt_r;
      streak_s    = streak_r;
      fill_s      = fill_r;
      srcByte_s   = fill_r ? FILL_BYTE : (rdSel_r ? DataPb : DataRt);
      addrInc_s   = (rdAddr_r == LAST_ADDR) ? rdAddr_r : (rdAddr_r + ADDR_W'(1));

      case (state_r)
         IDLE: begin
            // Address 0 is presented while idle so the RAM already holds byte 0 during PREFETCH.
            rdAddr_s = {ADDR_W{1'b0}};
            if (ReqRt || ReqPb) begin
               nextState_s = PREFETCH;
               busy_s      = 1'b1;
               fill_s      = 1'b0;
               if (ReqPb && (!ReqRt || (streak_r == STREAK_MAX))) begin
                  rdSel_s  = 1'b1;
                  streak_s = {STREAK_W{1'b0}};
               end else begin
                  rdSel_s = 1'b0;
                  if (ReqPb) begin
                     streak_s = (streak_r == STREAK_MAX) ? streak_r : (streak_r + STREAK_W'(1));
                  end else begin
                     streak_s = {STREAK_W{1'b0}};
                  end
               end
            end else begin
`ifdef TM_FILL_FRAME_EN
               nextState_s = PREFETCH;
               busy_s      = 1'b1;
               fill_s      = 1'b1;
               rdSel_s     = 1'b0;
`else
               nextState_s = IDLE;
               busy_s      = 1'b0;
`endif
            end
         end

         PREFETCH: begin
            nextState_s = SEND;
            serEn_s     = 1'b1;
            byteO_s     = srcByte_s;
            bitCnt_s    = 3'd0;
            byteCnt_s   = {ADDR_W{1'b0}};
            rdAddr_s    = addrInc_s;
         end

         SEND: begin
            bitCnt_s = bitCnt_r + 3'd1;
            if (bitCnt_r == 3'd7) begin
               if (byteCnt_r == LAST_ADDR) begin
                  serEn_s  = 1'b0;
                  doneRt_s = !fill_r && !rdSel_r;
                  donePb_s = !fill_r && rdSel_r;
                  rdAddr_s = {ADDR_W{1'b0}};
                  gapCnt_s = {GAP_W{1'b0}};
                  if (GAP_BITS == 0) begin
                     nextState_s = IDLE;
                     busy_s      = 1'b0;
                  end else begin
                     nextState_s = GAP;
                  end
               end else begin
                  byteO_s   = srcByte_s;
                  byteCnt_s = byteCnt_r + ADDR_W'(1);
                  rdAddr_s  = addrInc_s;
               end
            end else begin
               byteO_s = byteO_r;
            end
         end

         GAP: begin
            if (gapCnt_r == GAP_LAST) begin
               nextState_s = IDLE;
               busy_s      = 1'b0;
            end else begin
               gapCnt_s = gapCnt_r + GAP_W'(1);
            end
         end

         default: begin
            nextState_s = IDLE;
            serEn_s     = 1'b0;
            busy_s      = 1'b0;
            rdAddr_s    = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State and registered-output update; reset aborts any frame without a Done pulse.
   always_ff @(posedge ClkI or negedge Rst) begin
      if (!Rst) begin
         state_r   <= IDLE;
         rdAddr_r  <= {ADDR_W{1'b0}};
         rdSel_r   <= 1'b0;
         byteO_r   <= 8'h00;
         serEn_r   <= 1'b0;
         doneRt_r  <= 1'b0;
         donePb_r  <= 1'b0;
         busy_r    <= 1'b0;
         bitCnt_r  <= 3'd0;
         byteCnt_r <= {ADDR_W{1'b0}};
         gapCnt_r  <= {GAP_W{1'b0}};
         streak_r  <= {STREAK_W{1'b0}};
         fill_r    <= 1'b0;
      end else begin
         state_r   <= nextState_s;
         rdAddr_r  <= rdAddr_s;
         rdSel_r   <= rdSel_s;
         byteO_r   <= byteO_s;
         serEn_r   <= serEn_s;
         doneRt_r  <= doneRt_s;
         donePb_r  <= donePb_s;
         busy_r    <= busy_s;
         bitCnt_r  <= bitCnt_s;
         byteCnt_r <= byteCnt_s;
         gapCnt_r  <= gapCnt_s;
         streak_r  <= streak_s;
         fill_r    <= fill_s;
      end
   end

   assign RdAddr = rdAddr_r;
   assign RdSel  = rdSel_r;
   assign ByteO  = byteO_r;
   assign SerEn  = serEn_r;
   assign DoneRt = doneRt_r;
   assign DonePb = donePb_r;
   assign Busy   = busy_r;

endmodule

// File: tb/tb_tm_frame_scheduler.sv
// Directed self-checking bench for tm_frame_scheduler (4-byte frames, gap 2; plus a 2-byte, gap-0 instance).
module tb_tm_frame_scheduler;

   logic       ClkI, Rst;
   logic       ReqRt, ReqPb;
   logic [7:0] DataRt, DataPb;
   logic [7:0] RdAddr;
   logic       RdSel, SerEn, DoneRt, DonePb, Busy;
   logic [7:0] ByteO;

   logic       ReqRt0, ReqPb0;
   logic [7:0] DataRt0, DataPb0;
   logic [7:0] RdAddr0;
   logic       RdSel0, SerEn0, DoneRt0, DonePb0, Busy0;
   logic [7:0] ByteO0;

   logic [7:0] ramRt [0:3];
   logic [7:0] ramPb [0:3];
   logic [9:0] expPb;

   int passCnt, totalCnt;
   int hiCnt, loCnt, busyCnt, doneCnt;
   logic got, pb, running;

   tm_frame_scheduler #(.FRAME_BYTES(4), .ADDR_W(8), .GAP_BITS(2), .MAX_RT_STREAK(4), .FILL_BYTE(8'h55)) u_dut (
      .ClkI(ClkI), .Rst(Rst), .ReqRt(ReqRt), .ReqPb(ReqPb), .DataRt(DataRt), .DataPb(DataPb),
      .RdAddr(RdAddr), .RdSel(RdSel), .ByteO(ByteO), .SerEn(SerEn), .DoneRt(DoneRt), .DonePb(DonePb), .Busy(Busy));

   tm_frame_scheduler #(.FRAME_BYTES(2), .ADDR_W(8), .GAP_BITS(0), .MAX_RT_STREAK(4), .FILL_BYTE(8'h55)) u_dut0 (
      .ClkI(ClkI), .Rst(Rst), .ReqRt(ReqRt0), .ReqPb(ReqPb0), .DataRt(DataRt0), .DataPb(DataPb0),
      .RdAddr(RdAddr0), .RdSel(RdSel0), .ByteO(ByteO0), .SerEn(SerEn0), .DoneRt(DoneRt0), .DonePb(DonePb0), .Busy(Busy0));

   initial ClkI = 1'b0;
   always #5 ClkI = ~ClkI;

   // Synchronous RAM models with one cycle of read latency.
   always_ff @(posedge ClkI) begin
      DataRt  <= (RdAddr < 8'd4) ? ramRt[RdAddr[1:0]] : 8'hFF;
      DataPb  <= (RdAddr < 8'd4) ? ramPb[RdAddr[1:0]] : 8'hFF;
      DataRt0 <= 8'hC0 ^ RdAddr0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt = totalCnt + 1;
      assert (obs === exp) passCnt = passCnt + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      passCnt = 0; totalCnt = 0;
      ramRt[0] = 8'hA1; ramRt[1] = 8'hB2; ramRt[2] = 8'hC3; ramRt[3] = 8'hD4;
      ramPb[0] = 8'h11; ramPb[1] = 8'h22; ramPb[2] = 8'h33; ramPb[3] = 8'h44;
      expPb = 10'b10_0001_0000;
      Rst = 1'b0; ReqRt = 1'b0; ReqPb = 1'b0; ReqRt0 = 1'b0; ReqPb0 = 1'b0; DataPb0 = 8'h00;

      repeat (3) @(negedge ClkI);
      chk("rst_rdAddr", RdAddr, 8'h00);
      chk("rst_rdSel", RdSel, 1'b0);
      chk("rst_byteO", ByteO, 8'h00);
      chk("rst_serEn", SerEn, 1'b0);
      chk("rst_doneRt", DoneRt, 1'b0);
      chk("rst_donePb", DonePb, 1'b0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_serEn0", SerEn0, 1'b0);

      Rst = 1'b1;
      repeat (3) @(negedge ClkI);
      chk("idle_serEn", SerEn, 1'b0);
      chk("idle_busy", Busy, 1'b0);

      // Frame 1: request seen in cycle 0.
      ReqRt = 1'b1;
      @(negedge ClkI);
      chk("pre_busy", Busy, 1'b1);
      chk("pre_serEn", SerEn, 1'b0);
      chk("pre_rdAddr", RdAddr, 8'h00);
      chk("pre_rdSel", RdSel, 1'b0);
      for (int i = 0; i < 32; i++) begin
         @(negedge ClkI);
         chk("f1_serEn", SerEn, 1'b1);
         chk("f1_byte", ByteO, ramRt[i/8]);
         chk("f1_doneRt", DoneRt, 1'b0);
         if ((i % 8) == 0) chk("f1_rdAddr", RdAddr, (i/8 + 1 > 3) ? 3 : i/8 + 1);
      end
      @(negedge ClkI);
      chk("f1_end_serEn", SerEn, 1'b0);
      chk("f1_end_doneRt", DoneRt, 1'b1);
      chk("f1_end_busy", Busy, 1'b1);
      @(negedge ClkI);
      chk("gap2_doneRt", DoneRt, 1'b0);
      chk("gap2_serEn", SerEn, 1'b0);
      chk("gap2_busy", Busy, 1'b1);
      @(negedge ClkI);
      chk("arb_idle_busy", Busy, 1'b0);
      chk("arb_idle_serEn", SerEn, 1'b0);
      @(negedge ClkI);
      chk("f2_pre_busy", Busy, 1'b1);
      chk("f2_pre_serEn", SerEn, 1'b0);
      @(negedge ClkI);
      chk("f2_serEn", SerEn, 1'b1);
      chk("f2_byte0", ByteO, 8'hA1);

      // Abort at bit 13 of frame 2.
      repeat (13) @(negedge ClkI);
      chk("bit13_serEn", SerEn, 1'b1);
      chk("bit13_byte", ByteO, 8'hB2);
      Rst = 1'b0;
      #1;
      chk("abort_serEn", SerEn, 1'b0);
      chk("abort_byteO", ByteO, 8'h00);
      chk("abort_rdAddr", RdAddr, 8'h00);
      chk("abort_busy", Busy, 1'b0);
      chk("abort_doneRt", DoneRt, 1'b0);
      repeat (2) @(negedge ClkI);
      chk("abort_hold_doneRt", DoneRt, 1'b0);
      chk("abort_hold_donePb", DonePb, 1'b0);
      Rst = 1'b1;
      @(negedge ClkI);
      chk("restart_busy", Busy, 1'b1);
      chk("restart_rdAddr", RdAddr, 8'h00);
      chk("restart_serEn", SerEn, 1'b0);
      @(negedge ClkI);
      chk("restart_serEn_hi", SerEn, 1'b1);
      chk("restart_byte0", ByteO, 8'hA1);
      chk("restart_rdAddr1", RdAddr, 8'h01);
      ReqRt = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 60 && !got; w++) begin
         @(negedge ClkI);
         if (DoneRt) got = 1'b1;
      end
      chk("restart_done", got, 1'b1);

      // Both requests held: grant order RT x4, PB, RT x4, PB.
      ReqRt = 1'b1; ReqPb = 1'b1;
      for (int k = 0; k < 10; k++) begin
         got = 1'b0; pb = 1'b0;
         for (int w = 0; w < 100 && !got; w++) begin
            @(negedge ClkI);
            if (DoneRt || DonePb) begin
               got = 1'b1;
               pb  = DonePb;
            end
         end
         chk("arb_done", got, 1'b1);
         chk("arb_grant_pb", pb, expPb[k]);
      end
      ReqRt = 1'b0; ReqPb = 1'b0;
      repeat (5) @(negedge ClkI);
      chk("arb_after_busy", Busy, 1'b0);
      chk("arb_after_serEn", SerEn, 1'b0);

      // Playback request dropped after 3 cycles still yields one full frame.
      ReqPb = 1'b1;
      got = 1'b0; hiCnt = 0;
      for (int c = 1; c <= 100 && !got; c++) begin
         @(negedge ClkI);
         if (c == 1) begin
            chk("pb_rdSel", RdSel, 1'b1);
            chk("pb_busy", Busy, 1'b1);
         end
         if (c == 3) ReqPb = 1'b0;
         if (SerEn) begin
            if (hiCnt == 0) chk("pb_byte0", ByteO, 8'h11);
            hiCnt = hiCnt + 1;
         end
         if (DonePb) got = 1'b1;
      end
      chk("pb_done", got, 1'b1);
      chk("pb_serEn_len", hiCnt, 32);
      hiCnt = 0; busyCnt = 0; doneCnt = 0;
      repeat (50) begin
         @(negedge ClkI);
         if (SerEn) hiCnt = hiCnt + 1;
         if (Busy && !DonePb) busyCnt = busyCnt + 1;
         if (DonePb || DoneRt) doneCnt = doneCnt + 1;
      end
      chk("pb_no_second_serEn", hiCnt, 0);
      chk("pb_no_second_done", doneCnt, 0);
      chk("pb_gap_busy_cycles", busyCnt, 1);

      // Gap-0 instance: back-to-back frames with exactly 2 SerEn-low cycles.
      ReqRt0 = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge ClkI);
         if (SerEn0) got = 1'b1;
      end
      chk("g0_rise", got, 1'b1);
      chk("g0_byte0", ByteO0, 8'hC0);
      chk("g0_rdSel", RdSel0, 1'b0);
      chk("g0_busy", Busy0, 1'b1);
      hiCnt = 1; running = 1'b1;
      for (int w = 0; w < 40 && running; w++) begin
         @(negedge ClkI);
         if (SerEn0) hiCnt = hiCnt + 1;
         else running = 1'b0;
      end
      chk("g0_serEn_len", hiCnt, 16);
      chk("g0_doneRt", DoneRt0, 1'b1);
      chk("g0_donePb", DonePb0, 1'b0);
      loCnt = 1; running = 1'b1;
      for (int w = 0; w < 10 && running; w++) begin
         @(negedge ClkI);
         if (!SerEn0) loCnt = loCnt + 1;
         else running = 1'b0;
      end
      chk("g0_low_len", loCnt, 2);
      chk("g0_byte0_again", ByteO0, 8'hC0);
      ReqRt0 = 1'b0;

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
